inv_sub_bytes_iter: RTL and testbench
=====================================

Name: inv_sub_bytes_iter

Overview:
- Iterative InvSubBytes stage for the AES decryption datapath; the inverse of the forward byte-substitution layer.
- Accepts a 128-bit state over a valid/ready handshake and applies the AES inverse S-box to every byte.
- Uses BYTES_PER_CYCLE shared inverse S-box instances over several cycles, trading latency for area.
- Sits between InvShiftRows and AddRoundKey in the iterative decryption round.

Parameters:
- DATA_LEN, 128, state width in bits; must be a multiple of 8.
- NUM_OF_BYTES, DATA_LEN>>3, number of bytes substituted per block.
- BYTES_PER_CYCLE, 4, inverse S-box instances; must divide NUM_OF_BYTES.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  input block valid
- ready_in  output  1  block can be accepted this cycle
- data_in  input  DATA_LEN  ciphertext-side state; byte i = data_in[8i+7:8i]
- valid_out  output  1  data_out holds a completed block
- ready_out  input  1  downstream accepts data_out
- data_out  output  DATA_LEN  substituted state; byte i = InvSbox(data_in byte i)
- busy  output  1  high while in BUSY state

Behaviour:
- One clock domain: clk.
- Reset is asynchronous and active-high on port reset.
- Reset values:
  - state = IDLE
  - valid_out = 0, busy = 0, ready_in = 1
  - data_out = 0
  - group counter = 0
- Inverse S-box: combinational per instance; full FIPS-197 inverse table.
  - Spot values: InvSbox(0x63)=0x00, InvSbox(0x7C)=0x01, InvSbox(0x00)=0x52, InvSbox(0x16)=0xFF, InvSbox(0xED)=0x53.
- Internal working register: DATA_LEN bits; data_out is driven from it.
- Group counter: NG = NUM_OF_BYTES/BYTES_PER_CYCLE groups; counter width clog2(NG), minimum 1.
- FSM states:
  - IDLE: ready_in=1. On valid_in=1, load data_in into the working register, clear the counter, go to BUSY.
  - BUSY: ready_in=0, busy=1, input ignored.
    - Each cycle, replace bytes [g*BPC .. g*BPC+BPC-1] with their inverse S-box values, where g = counter; increment the counter.
    - Group 0 (least significant bytes) is processed first.
    - After group NG-1 is written, go to DONE with valid_out=1.
  - DONE: valid_out=1; data_out stable while ready_out=0.
    - ready_in = ready_out (combinational).
    - ready_out=1 and valid_in=0: clear valid_out, go to IDLE.
    - ready_out=1 and valid_in=1: output retires and the new block loads on the same edge; go to BUSY (back-to-back, no bubble).
- Latency: NG clock edges from the accepting edge to valid_out high. Default is 4.
- Throughput:
  - One block per NG+1 cycles when downstream always ready.
  - Back-to-back loading via DONE gives one block per NG+1 cycles; no faster.
- valid_out must never fall without a handshake (valid_out && ready_out).
- Reset asserted mid-BUSY or in DONE: the block in flight is discarded; all outputs return to reset values immediately (asynchronous).
- BYTES_PER_CYCLE = NUM_OF_BYTES: NG = 1, single-cycle BUSY, latency 1.
- valid_in held high in BUSY: no effect and no second capture.
- data_in changing after acceptance: no effect on the result.

Test Plan:
1. Reset with data_in all 0x63, then valid_in pulse, ready_out=1.
   -> ready_in low for 4 BUSY cycles plus DONE (ready_in goes high combinationally in DONE because ready_out=1).
   -> valid_out high exactly 4 edges after accept, data_out = 128'h0, for one cycle.
2. data_in = 128'h0 -> data_out = {16{8'h52}}.
   data_in = {16{8'h16}} -> data_out = {16{8'hFF}}.
   Byte-order check: data_in = 128'h...ED7C (byte0=0x7C, byte1=0xED, rest 0x63) -> byte0=0x01, byte1=0x53, rest 0x00.
3. Backpressure: ready_out=0 for 10 cycles after valid_out rises.
   -> data_out and valid_out stay stable; ready_in stays 0.
   -> Release ready_out: block retires in one cycle.
4. Back-to-back: valid_in held high with two blocks, ready_out=1.
   -> Second block accepted on the DONE-retire edge.
   -> Outputs arrive 5 cycles apart, both correct.
5. Assert reset two cycles into BUSY.
   -> valid_out=0, busy=0, ready_in=1 immediately.
   -> After release, a new block completes correctly with no residue from the old one.
6. Full table sweep: 16 blocks, each carrying bytes 0x00..0xFF.
   -> InvSbox(SubBytes model(x)) = x for all 256 values.
   -> Repeat with BYTES_PER_CYCLE = 1, 2 and 16: latencies 16, 8, 1.

Source files
------------

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: a 128-bit state is substituted BYTES_PER_CYCLE bytes per clock
// through a small bank of shared inverse S-boxes, behind a valid/ready handshake.

module inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // FIPS-197 inverse S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] INV_TAB = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry b sits at bit 8*(255-b); for an 8-bit b, 255-b is simply ~b.
    assign out_byte = INV_TAB[{~in_byte, 3'b000} +: 8];
endmodule

module inv_sub_bytes_iter #(
    parameter int DATA_LEN        = 128,
    parameter int NUM_OF_BYTES    = DATA_LEN >> 3,
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    output logic                ready_in,
    input  logic [DATA_LEN-1:0] data_in,
    output logic                valid_out,
    input  logic                ready_out,
    output logic [DATA_LEN-1:0] data_out,
    output logic                busy
);
    localparam int NG = NUM_OF_BYTES / BYTES_PER_CYCLE;
    localparam int CW = (NG > 1) ? $clog2(NG) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_LEN-1:0]   work_q, work_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;

    logic [BYTES_PER_CYCLE-1:0][7:0] grp_in, grp_out;

    for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_lane
        assign grp_in[b] = work_q[(int'(cnt_q) * BYTES_PER_CYCLE + b) * 8 +: 8];
        inv_sbox u_sbox (
            .in_byte (grp_in[b]),
            .out_byte(grp_out[b])
        );
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    work_d  = data_in;
                    cnt_d   = '0;
                    state_d = BUSY;
                    busy_d  = 1'b1;
                end
            end
            BUSY: begin
                for (int i = 0; i < BYTES_PER_CYCLE; i++)
                    work_d[(int'(cnt_q) * BYTES_PER_CYCLE + i) * 8 +: 8] = grp_out[i];
                if (cnt_q == CW'(NG - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // Retiring and reloading share one edge so back-to-back blocks see no bubble.
                if (ready_out) begin
                    valid_d = 1'b0;
                    if (valid_in) begin
                        work_d  = data_in;
                        cnt_d   = '0;
                        state_d = BUSY;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign ready_in  = (state_q == IDLE) || ((state_q == DONE) && ready_out);
    assign valid_out = valid_q;
    assign busy      = busy_q;
    assign data_out  = work_q;
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: four instances (4, 1, 2, 16 bytes per cycle) checked every
// cycle against a block-level model whose S-box is derived from GF(2^8) arithmetic.

module tb_inv_sub_bytes_iter;
    logic         clk = 1'b0;
    logic         reset;
    logic         vin  [4];
    logic         rin  [4];
    logic [127:0] din  [4];
    logic         vout [4];
    logic         rout [4];
    logic [127:0] dout [4];
    logic         bsy  [4];

    int n_chk = 0;
    int n_err = 0;
    int ng_tab [4] = '{4, 16, 8, 1};

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    int           m_cnt [4];
    bit           m_has [4];
    logic [127:0] m_exp [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int BPC = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 16;
        inv_sub_bytes_iter #(.DATA_LEN(128), .BYTES_PER_CYCLE(BPC)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .valid_in (vin[g]),
            .ready_in (rin[g]),
            .data_in  (din[g]),
            .valid_out(vout[g]),
            .ready_out(rout[g]),
            .data_out (dout[g]),
            .busy     (bsy[g])
        );
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from its definition: multiplicative inverse, then the affine map.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] iv;
        iv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) iv = 8'(y);
        return iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] inv_blk(input logic [127:0] d);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[8*j +: 8] = inv_tab[d[8*j +: 8]];
        return r;
    endfunction

    // Block-level reference: a pending block is invisible for NG cycles, then held until taken.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                chk($sformatf("rst_vout%0d", k), vout[k], 1'b0);
                chk($sformatf("rst_busy%0d", k), bsy[k], 1'b0);
                chk($sformatf("rst_rdy%0d", k), rin[k], 1'b1);
                chk($sformatf("rst_data%0d", k), dout[k], 128'h0);
                m_cnt[k] = 0;
                m_has[k] = 1'b0;
            end else begin
                if (m_cnt[k] > 0) begin
                    chk($sformatf("busy%0d", k), bsy[k], 1'b1);
                    chk($sformatf("busy_rdy%0d", k), rin[k], 1'b0);
                    chk($sformatf("busy_vout%0d", k), vout[k], 1'b0);
                    m_cnt[k]--;
                end else if (m_has[k]) begin
                    chk($sformatf("done_busy%0d", k), bsy[k], 1'b0);
                    chk($sformatf("done_vout%0d", k), vout[k], 1'b1);
                    chk($sformatf("done_rdy%0d", k), rin[k], rout[k]);
                    chk($sformatf("done_data%0d", k), dout[k], m_exp[k]);
                    if (rout[k]) begin
                        m_has[k] = 1'b0;
                        if (vin[k]) begin
                            m_cnt[k] = ng_tab[k];
                            m_has[k] = 1'b1;
                            m_exp[k] = inv_blk(din[k]);
                        end
                    end
                end else begin
                    chk($sformatf("idle_busy%0d", k), bsy[k], 1'b0);
                    chk($sformatf("idle_vout%0d", k), vout[k], 1'b0);
                    chk($sformatf("idle_rdy%0d", k), rin[k], 1'b1);
                    if (vin[k]) begin
                        m_cnt[k] = ng_tab[k];
                        m_has[k] = 1'b1;
                        m_exp[k] = inv_blk(din[k]);
                    end
                end
            end
        end
    end

    // Present a block and hold it until accepted; reports what the output looked like then.
    task automatic send(input int k, input logic [127:0] d, output logic vo, output logic [127:0] dd);
        bit ok;
        ok = 1'b0;
        vo = 1'b0;
        dd = '0;
        din[k] = d;
        vin[k] = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (rin[k]) begin
                ok = 1'b1;
                vo = vout[k];
                dd = dout[k];
            end
        end
        if (!ok) chk($sformatf("accept_timeout%0d", k), 1'b0, 1'b1);
        @(posedge clk); #1;
        vin[k] = 1'b0;
    endtask

    // Returns at the first negedge with valid_out high; lat counts edges after the accept edge.
    task automatic wait_out(input int k, output logic [127:0] d, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = -1;
        d   = '0;
        for (int t = 1; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (vout[k]) begin
                ok  = 1'b1;
                lat = t - 1;
                d   = dout[k];
            end
        end
        if (!ok) chk($sformatf("output_timeout%0d", k), 1'b0, 1'b1);
    endtask

    initial begin
        logic [127:0] d, e, got, held;
        logic         vo;
        int           lat;

        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vin[k] = 1'b0; din[k] = '0; rout[k] = 1'b1;
            m_cnt[k] = 0; m_has[k] = 1'b0; m_exp[k] = '0;
        end
        din[0] = {16{8'h63}};
        for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_fwd(8'(x));
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

        chk("model_fwd00", fwd_tab[8'h00], 8'h63);
        chk("model_inv63", inv_tab[8'h63], 8'h00);
        chk("model_inv7c", inv_tab[8'h7c], 8'h01);
        chk("model_inv00", inv_tab[8'h00], 8'h52);
        chk("model_inv16", inv_tab[8'h16], 8'hff);
        chk("model_inved", inv_tab[8'hed], 8'h53);

        repeat (2) @(posedge clk); #1;
        reset = 1'b0;

        // All-0x63 block: zero result after exactly four edges, shown for one cycle.
        send(0, {16{8'h63}}, vo, got);
        wait_out(0, got, lat);
        chk("t1_data", got, 128'h0);
        chk("t1_lat", lat, 4);
        @(posedge clk); #1;
        chk("t1_one_cycle", vout[0], 1'b0);

        send(0, 128'h0, vo, got);
        wait_out(0, got, lat);
        chk("t2_zero", got, {16{8'h52}});
        @(posedge clk); #1;
        send(0, {16{8'h16}}, vo, got);
        wait_out(0, got, lat);
        chk("t2_16", got, {16{8'hff}});
        @(posedge clk); #1;
        send(0, {{14{8'h63}}, 8'hed, 8'h7c}, vo, got);
        wait_out(0, got, lat);
        chk("t2_order", got, {{14{8'h00}}, 8'h53, 8'h01});
        @(posedge clk); #1;

        // Backpressure: output frozen while downstream stalls.
        rout[0] = 1'b0;
        send(0, {16{8'h7c}}, vo, got);
        wait_out(0, held, lat);
        chk("t3_data", held, {16{8'h01}});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_vout", vout[0], 1'b1);
            chk("t3_hold_data", dout[0], held);
            chk("t3_hold_rdy", rin[0], 1'b0);
        end
        @(posedge clk); #1;
        rout[0] = 1'b1;
        @(negedge clk);
        chk("t3_release_vout", vout[0], 1'b1);
        @(posedge clk); #1;
        chk("t3_retired", vout[0], 1'b0);

        // Back-to-back: second block held on valid_in through BUSY, taken on the retire edge.
        send(0, {16{8'h63}}, vo, got);
        send(0, {16{8'h16}}, vo, got);
        chk("t4_first_vout_at_accept", vo, 1'b1);
        chk("t4_first_data", got, 128'h0);
        wait_out(0, got, lat);
        chk("t4_second_data", got, {16{8'hff}});
        chk("t4_gap", lat + 1, 5);
        @(posedge clk); #1;

        // Reset in the second BUSY cycle drops the block at once.
        send(0, {16{8'h00}}, vo, got);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t5_vout", vout[0], 1'b0);
        chk("t5_busy", bsy[0], 1'b0);
        chk("t5_rdy", rin[0], 1'b1);
        chk("t5_data", dout[0], 128'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        send(0, {16{8'h16}}, vo, got);
        wait_out(0, got, lat);
        chk("t5_after", got, {16{8'hff}});
        chk("t5_lat", lat, 4);
        @(posedge clk); #1;

        // Table sweep: feed SubBytes(x) for every x on every width; x must come back.
        for (int k = 0; k < 4; k++) begin
            for (int blk = 0; blk < 16; blk++) begin
                for (int j = 0; j < 16; j++) begin
                    d[8*j +: 8] = fwd_tab[blk*16 + j];
                    e[8*j +: 8] = 8'(blk*16 + j);
                end
                send(k, d, vo, got);
                wait_out(k, got, lat);
                chk($sformatf("t6_data%0d_%0d", k, blk), got, e);
                chk($sformatf("t6_lat%0d_%0d", k, blk), lat, ng_tab[k]);
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
